// File: rtl/m_arbiter.sv
// m_arbiter: round-robin front end sharing one RV32M multiply/divide unit between two requesters.
// Optional abort-on-timeout is built in when the macro M_ARB_TIMEOUT_EN is defined.
module m_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_0,
  input  logic [31:0] instruction_0,
  input  logic [31:0] rs1_0,
  input  logic [31:0] rs2_0,
  output logic        wr_0,
  output logic [31:0] rd_0,
  output logic        busy_0,
  output logic        ready_0,
  input  logic        valid_1,
  input  logic [31:0] instruction_1,
  input  logic [31:0] rs1_1,
  input  logic [31:0] rs2_1,
  output logic        wr_1,
  output logic [31:0] rd_1,
  output logic        busy_1,
  output logic        ready_1,
  output logic        m_valid,
  output logic [31:0] m_instruction,
  output logic [31:0] m_rs1,
  output logic [31:0] m_rs2,
  input  logic        m_wr,
  input  logic [31:0] m_rd,
  input  logic        m_busy,
  input  logic        m_ready,
  output logic        err
);

  if (TIMEOUT_CYCLES < 1) begin : g_badTimeout
    $error("m_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_lastGrant;
  logic        r_grant;
  logic [31:0] r_instr;
  logic [31:0] r_rs1;
  logic [31:0] r_rs2;
  logic        r_wr;
  logic [31:0] r_rd;
  logic        r_keep;

  logic        w_elig0;
  logic        w_elig1;
  logic        w_anyElig;
  logic        w_sel;
  logic        w_grantValid;
  logic        w_inService;
  logic        w_ready;
  logic        w_timeout;

  // Only register-register MUL/DIV/REM (OP opcode, funct7 = MULDIV) may reach the shared unit.
  assign w_elig0      = valid_0 && (instruction_0[6:0] == 7'b0110011) && (instruction_0[31:25] == 7'b0000001);
  assign w_elig1      = valid_1 && (instruction_1[6:0] == 7'b0110011) && (instruction_1[31:25] == 7'b0000001);
  assign w_anyElig    = w_elig0 || w_elig1;
  assign w_sel        = (w_elig0 && w_elig1) ? ~r_lastGrant : w_elig1;
  assign w_grantValid = r_grant ? valid_1 : valid_0;
  assign w_inService  = (r_state == ISSUE) || (r_state == WAIT);

`ifdef M_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic          r_timedOut;

  assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  // r_cnt equals the number of cycles already spent in ISSUE/WAIT for the current operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_timedOut <= 1'b0;
    end else begin
      if (w_inService) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
      if (r_state == IDLE) begin
        r_timedOut <= 1'b0;
      end else if (w_inService && !m_ready && w_timeout) begin
        r_timedOut <= 1'b1;
      end
    end
  end

  assign err = w_ready && r_timedOut;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_anyElig) w_next = ISSUE;
      ISSUE: begin
        if (m_ready || w_timeout) begin
          w_next = RESP;
        end else if (m_busy) begin
          w_next = WAIT;
        end
      end
      WAIT:  if (m_ready || w_timeout) w_next = RESP;
      RESP:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // r_keep drops if the granted requester withdraws mid-operation; its result is then discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_lastGrant <= 1'b1;
      r_grant     <= 1'b0;
      r_instr     <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_wr        <= 1'b0;
      r_rd        <= '0;
      r_keep      <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && w_anyElig) begin
        r_grant     <= w_sel;
        r_lastGrant <= w_sel;
        r_instr     <= w_sel ? instruction_1 : instruction_0;
        r_rs1       <= w_sel ? rs1_1 : rs1_0;
        r_rs2       <= w_sel ? rs2_1 : rs2_0;
        r_wr        <= 1'b0;
        r_rd        <= '0;
        r_keep      <= 1'b1;
      end else if (w_inService) begin
        r_keep <= r_keep && w_grantValid;
        if (m_ready) begin
          r_wr <= m_wr;
          r_rd <= m_rd;
        end else if (w_timeout) begin
          r_wr <= 1'b0;
          r_rd <= '0;
        end
      end
    end
  end

  assign w_ready       = (r_state == RESP) && r_keep;
  assign m_valid       = w_inService;
  assign m_instruction = w_inService ? r_instr : '0;
  assign m_rs1         = w_inService ? r_rs1 : '0;
  assign m_rs2         = w_inService ? r_rs2 : '0;

  assign busy_0  = (r_state != IDLE) && !r_grant;
  assign busy_1  = (r_state != IDLE) && r_grant;
  assign ready_0 = w_ready && !r_grant;
  assign ready_1 = w_ready && r_grant;
  assign wr_0    = ready_0 && r_wr;
  assign wr_1    = ready_1 && r_wr;
  assign rd_0    = ready_0 ? r_rd : '0;
  assign rd_1    = ready_1 ? r_rd : '0;

endmodule

// File: doc/m_arbiter.md
M_ARBITER -- requirements
Module: m_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: max cycles in ISSUE+WAIT before abort; only used when M_ARB_TIMEOUT_EN is defined.
REQ-002 The clock and reset SHALL be: clk  input  1  single clock, all state on rising edge; reset  input  1  synchronous, active-high reset.
REQ-003 Requester ports x in {0,1} SHALL be: valid_x  input  1  request; instruction_x  input  32  instruction word; rs1_x  input  32  operand A; rs2_x  input  32  operand B.
REQ-004 Requester response ports SHALL be: wr_x  output  1  write rd; rd_x  output  32  result; busy_x  output  1  request accepted, in service; ready_x  output  1  one-cycle completion strobe.
REQ-005 Downstream ports to the shared M unit SHALL be: m_valid  output  1; m_instruction  output  32; m_rs1  output  32; m_rs2  output  32; m_wr  input  1; m_rd  input  32; m_busy  input  1; m_ready  input  1.
REQ-006 The error port SHALL be: err  output  1  one-cycle pulse, coincident with ready_x, on a timeout abort.

Function
REQ-007 A request SHALL be eligible only when valid_x=1, instruction_x[6:0]=7'b0110011 and instruction_x[31:25]=7'b0000001; ineligible requests SHALL never raise busy_x or m_valid.
REQ-008 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, RESP.
REQ-009 In IDLE with one eligible requester, that requester SHALL be granted. With two eligible requesters, the requester not named by last_grant SHALL be granted. The grant SHALL register instruction/rs1/rs2 into holding registers, update last_grant, and move to ISSUE.
REQ-010 In ISSUE and WAIT, m_valid SHALL be 1 and m_instruction/m_rs1/m_rs2 SHALL come from the holding registers.
REQ-011 ISSUE SHALL move to WAIT when m_busy=1 and m_ready=0. ISSUE or WAIT SHALL move to RESP when m_ready=1, capturing m_wr and m_rd in that cycle.
REQ-012 In RESP, ready_x=1 and wr_x/rd_x SHALL carry the captured values for the granted requester only, for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-013 busy_x SHALL be 1 from the cycle after grant through the RESP cycle inclusive, and 0 otherwise.
REQ-014 Non-granted requester outputs, and rd_x/wr_x outside RESP, SHALL be 0.
REQ-015 Minimum latency SHALL be: valid_x at cycle 0 -> m_valid at cycle 1 -> m_ready at cycle k (k>=1) -> ready_x at cycle k+1.
REQ-016 Requester contract: valid_x SHALL be held until ready_x and dropped in the following cycle. IDLE therefore SHALL NOT re-grant a completed request.
REQ-017 If the granted valid_x drops before m_ready, the downstream operation SHALL still complete. RESP SHALL then be entered with ready_x=0, and the result SHALL be discarded.
REQ-018 A new eligible request arriving during ISSUE, WAIT or RESP SHALL wait, unacknowledged, until IDLE.

Reset
REQ-019 With reset=1 at a clock edge, the FSM SHALL go to IDLE, last_grant=1 (requester 0 wins the first tie), and the holding, captured and timeout registers SHALL clear to 0.
REQ-020 On the cycle after reset, all outputs (m_valid, m_instruction, m_rs1, m_rs2, wr_x, rd_x, busy_x, ready_x, err) SHALL be 0.
REQ-021 Reset asserted mid-operation SHALL abort without producing any ready_x. The downstream unit SHALL be reset from the same reset source by the integrator.

Configuration
REQ-022 When macro M_ARB_TIMEOUT_EN is defined, a counter SHALL run in ISSUE/WAIT and clear in IDLE.
REQ-023 With M_ARB_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES without m_ready SHALL force RESP with wr_x=0, rd_x=0 and err=1.
REQ-024 With M_ARB_TIMEOUT_EN defined, a later m_ready for the aborted operation SHALL be ignored.
REQ-025 When M_ARB_TIMEOUT_EN is undefined, no counter SHALL exist, err SHALL be tied to 0, and WAIT SHALL wait indefinitely.

Verification
REQ-026 Single MUL: req0 MUL (0x02B50533) with rs1=7, rs2=6 -> m_valid next cycle; on m_ready, ready_0=1, wr_0=1, rd_0=42 one cycle later; requester 1 outputs stay 0.
REQ-027 Simultaneous requests after reset: both request MUL -> requester 0 served first; requester 1 granted in the first IDLE cycle after RESP; busy_1 stays 0 until then.
REQ-028 Round-robin: a second simultaneous pair of requests, with last_grant=0 -> requester 1 served first.
REQ-029 Ineligible request: req0 ADDI (opcode 0010011) for 10 cycles -> busy_0, ready_0 and m_valid stay 0.
REQ-030 Timeout (macro defined, TIMEOUT_CYCLES=64): m_ready held 0 -> ready_0=1, wr_0=0, rd_0=0, err=1 exactly 64 cycles after ISSUE entry.
REQ-031 Reset in WAIT: reset pulsed mid-operation -> next cycle all outputs 0, no ready_x pulse, and the next request is granted normally.
